// File: rtl/adc_trigger_packer_pkg.sv
// adc_trigger_pkg: shared types, constants and helpers for the ADC trigger packer
package adc_trigger_pkg;

    typedef enum logic [1:0] {ARMED, FIRE, HOLDOFF} trig_state_e;

    typedef logic signed [15:0] sample_t;

    localparam logic [7:0] ID_NONE = 8'd0;

    function automatic logic [15:0] sat_abs(input sample_t s);
        return (s == 16'sh8000) ? 16'h7FFF : (s[15] ? 16'(-s) : 16'(s));
    endfunction

endpackage

// File: rtl/adc_trigger_packer_if.sv
// adc_trigger_packer_if: ADC sample input, CSR controls and writer-facing outputs
interface adc_trigger_packer_if;
    import adc_trigger_pkg::*;

    logic        enable;
    logic        adc_valid;
    sample_t     adc_ch0;
    sample_t     adc_ch1;
    logic [15:0] threshold;
    logic [31:0] data;
    logic        data_valid;
    logic [7:0]  interrupt_id;
    logic [15:0] event_count;

    modport master (
        output enable, adc_valid, adc_ch0, adc_ch1, threshold,
        input  data, data_valid, interrupt_id, event_count
    );

    modport slave (
        input  enable, adc_valid, adc_ch0, adc_ch1, threshold,
        output data, data_valid, interrupt_id, event_count
    );

endinterface

// File: rtl/adc_trigger_packer_decim_avg.sv
// decim_avg: per-channel block accumulator producing the arithmetic-shifted average
module decim_avg
    import adc_trigger_pkg::*;
#(
    parameter int DECIM_LOG2 = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    clear,
    input  logic    valid,
    input  logic    last,
    input  sample_t sample,
    output sample_t avg
);
    localparam int W = 16 + DECIM_LOG2;

    logic signed [W-1:0] acc;
    logic signed [W-1:0] sum;

    assign sum = acc + W'(sample);
    assign avg = sample_t'(sum >>> DECIM_LOG2);

    // accumulate each accepted sample; the block's final sample restarts from zero
    always_ff @(posedge clk) begin
        if (reset || clear)
            acc <= '0;
        else if (valid)
            acc <= last ? '0 : sum;
    end

endmodule

// File: rtl/adc_trigger_packer.sv
// adc_trigger_packer: decimates two ADC channels into 32-bit words and flags threshold triggers
module adc_trigger_packer
    import adc_trigger_pkg::*;
#(
    parameter int DECIM_LOG2     = 2,
    parameter int HOLDOFF_CYCLES = 4096,
    parameter int ID_FIRST       = 1
) (
    input logic                 clk,
    input logic                 reset,
    adc_trigger_packer_if.slave bus
);
    localparam int              CW        = DECIM_LOG2 > 0 ? DECIM_LOG2 : 1;
    localparam int              HOLD      = HOLDOFF_CYCLES > 0 ? HOLDOFF_CYCLES : 1;
    localparam int              HW        = $clog2(HOLD + 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'((1 << DECIM_LOG2) - 1);
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD - 1);

    trig_state_e   state, next_state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    id_reg;
    sample_t       avg0, avg1;
    logic          take, last, word, hit;

    assign take = bus.enable && bus.adc_valid;
    assign last = cnt == CNT_LAST;
    assign word = take && last;
    assign hit  = word && (sat_abs(avg0) >= bus.threshold || sat_abs(avg1) >= bus.threshold);

    decim_avg #(.DECIM_LOG2(DECIM_LOG2)) u_ch0 (
        .clk(clk), .reset(reset), .clear(!bus.enable), .valid(take),
        .last(last), .sample(bus.adc_ch0), .avg(avg0)
    );

    decim_avg #(.DECIM_LOG2(DECIM_LOG2)) u_ch1 (
        .clk(clk), .reset(reset), .clear(!bus.enable), .valid(take),
        .last(last), .sample(bus.adc_ch1), .avg(avg1)
    );

    // trigger state register
    always_ff @(posedge clk) begin
        state <= reset ? ARMED : next_state;
    end

    // next state and event id output; the id is shown only while in FIRE
    always_comb begin
        next_state       = state;
        bus.interrupt_id = ID_NONE;
        if (state == FIRE)
            bus.interrupt_id = id_reg;
        next_state = !bus.enable      ? ARMED :
                     state == ARMED   ? (hit ? FIRE : ARMED) :
                     hold_cnt == '0   ? ARMED : HOLDOFF;
    end

    // sample counter and holdoff timer; the timer starts with the trigger so FIRE counts toward holdoff
    always_ff @(posedge clk) begin
        if (reset || !bus.enable) begin
            cnt      <= '0;
            hold_cnt <= '0;
        end else begin
            if (take)
                cnt <= last ? '0 : cnt + CW'(1);
            hold_cnt <= next_state == FIRE ? HOLD_LOAD :
                        hold_cnt != '0     ? hold_cnt - HW'(1) : '0;
        end
    end

    // id and event bookkeeping advance once per issued trigger and survive enable=0
    always_ff @(posedge clk) begin
        if (reset) begin
            id_reg          <= 8'(ID_FIRST);
            bus.event_count <= '0;
        end else if (state == FIRE) begin
            id_reg <= id_reg == 8'hFF ? 8'd1 : id_reg + 8'd1;
            if (bus.event_count != 16'hFFFF)
                bus.event_count <= bus.event_count + 16'd1;
        end
    end

    // packed output word, updated one cycle after the block's final sample
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data       <= '0;
            bus.data_valid <= 1'b0;
        end else begin
            bus.data_valid <= word;
            if (word)
                bus.data <= {avg1, avg0};
        end
    end

endmodule

// File: doc/adc_trigger_packer.md
Name: adc_trigger_packer

Overview:
- Upstream feeder of the SDRAM ring-buffer writer.
- Decimates a two-channel signed 16-bit ADC stream and packs each averaged pair into the 32-bit `data` word the writer samples.
- Detects threshold crossings and emits a one-cycle, non-zero 8-bit `interrupt_id` event.
- The writer latches its current ring-buffer address on that event.

Parameters:
- DECIM_LOG2, 2, log2 of samples averaged per output word (0 = no decimation, 1..6 legal)
- HOLDOFF_CYCLES, 4096, clk cycles after a trigger during which no new trigger is accepted
- ID_FIRST, 1, first event id issued after reset (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  capture enable from CSR
- adc_valid  in  1  one-cycle strobe: adc_ch0/adc_ch1 hold a new sample pair
- adc_ch0  in  16  channel 0 sample, two's complement
- adc_ch1  in  16  channel 1 sample, two's complement
- threshold  in  16  unsigned magnitude threshold, static while enable=1
- data  out  32  {avg_ch1, avg_ch0}, held between updates
- data_valid  out  1  one-cycle pulse when `data` updates
- interrupt_id  out  8  non-zero for exactly one cycle on trigger, 0 otherwise
- event_count  out  16  triggers since reset, saturating at 16'hFFFF

Behaviour:
- Reset values:
  - data = 0, data_valid = 0, interrupt_id = 0, event_count = 0.
  - Accumulators = 0, sample counter = 0, state = ARMED, id register = ID_FIRST.
- Accumulation:
  - Per-channel signed accumulator, width 16+DECIM_LOG2, sign-extended adds.
  - Each adc_valid with enable=1 adds both channels and increments the sample counter.
- Output word:
  - On the 2^DECIM_LOG2-th valid sample (cycle N), each average = accumulator (including that sample) arithmetic-shifted right by DECIM_LOG2, truncated to 16 bits.
  - At N+1: `data` updates, data_valid pulses, accumulators and counter clear.
  - Latency from the final adc_valid to data_valid is 1 cycle.
- Magnitude:
  - abs() of each 16-bit average; -32768 saturates to 32767.
  - Hit = (mag_ch0 >= threshold) OR (mag_ch1 >= threshold), evaluated only on the output-word cycle.
- FSM:
  - ARMED: hit on an output-word cycle -> FIRE.
  - FIRE (1 cycle):
    - interrupt_id = id register, driven in the same cycle as data_valid for the triggering word.
    - event_count increments, saturating.
    - id register increments, wrapping 255 -> 1 (0 never issued).
    - -> HOLDOFF.
  - HOLDOFF:
    - Counter loads HOLDOFF_CYCLES-1 on entry and decrements each clk.
    - At 0 -> ARMED.
    - Data packing continues; hits are ignored.
- Alignment: since FIRE coincides with data_valid, the writer's next captured address corresponds to the triggering word.
- enable=0:
  - Accumulators and sample counter are held at 0, state forced to ARMED, holdoff counter cleared.
  - data is held; data_valid = 0, interrupt_id = 0.
  - The id register and event_count are preserved.
- enable falling during FIRE: the pulse for that cycle still completes; next cycle obeys enable=0.
- adc_valid while enable=0 is ignored. adc_valid on the cycle enable rises is accepted.
- threshold = 0: every output word is a hit (subject to holdoff).
- HOLDOFF_CYCLES = 0 is treated as 1.
- Reset mid-accumulation or mid-holdoff: all state returns to reset values next cycle; a partial accumulation is discarded.
- Back-to-back adc_valid every cycle must be sustained with no dropped samples.

Decomposition:
- Package adc_trigger_pkg:
  - typedef trig_state_e {ARMED, FIRE, HOLDOFF}
  - typedef sample_t (logic signed [15:0])
  - constant ID_NONE = 8'd0
  - function sat_abs(sample_t) returning 16-bit unsigned
- Sub-module decim_avg:
  - One instance per channel.
  - Owns the accumulator and shift.
  - Shared sample counter drives both instances' `last` input.

Test Plan:
- DECIM_LOG2=2, ch0 = 100, 200, 300, 400, ch1 = -4 x4, threshold=1000 -> one data_valid, 1 cycle after the 4th sample; data = 32'hFFFC_00FA; interrupt_id stays 0.
- DECIM_LOG2=0, HOLDOFF_CYCLES=8, threshold=500, ch0 = 600 every cycle ->
  - interrupt_id = 1 with the first data_valid.
  - Next id = 2 exactly 9 cycles later, then every 9 cycles.
  - event_count tracks.
- ch1 = -32768 (16'h8000), threshold=32767 -> trigger fires (saturated abs); data[31:16] = 16'h8000.
- Force 256 triggers from reset -> ids run 1..255 then 1; id 0 is never observed; event_count = 256.
- Assert reset after 2 of 4 samples, then feed 4 samples of 8 -> a single data_valid with data[15:0] = 8 (no stale partial sum).
- Drop enable during HOLDOFF, raise it 2 cycles later, then feed a hit -> immediate trigger with the next sequential id; event_count preserved.
